// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, opcodes and FSM encodings for the PC stage
package pc_sequencer_pkg;

  localparam int DEF_PC_W      = 16;
  localparam int DEF_OFF_W     = 16;
  localparam int DEF_RESET_PC  = 0;
  localparam int DEF_STK_DEPTH = 8;

  // Opcodes shared with branch_controller and main control
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] OP_BMI  = 4'h9;
  localparam logic [3:0] OP_BPL  = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control-in / PC-out bundle between main control and the PC stage
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int CNT_W = $clog2(DEF_STK_DEPTH) + 1
);
  logic             pc_en;
  logic             Branch;
  logic [OFF_W-1:0] br_offset;
  logic             call;
  logic             ret;
  logic             halt;
  logic             resume;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic             stk_ovf;
  logic             stk_unf;
  logic [CNT_W-1:0] stk_cnt;

  modport master (
    output pc_en, Branch, br_offset, call, ret, halt, resume,
    input  pc, halted, stk_ovf, stk_unf, stk_cnt
  );

  modport slave (
    input  pc_en, Branch, br_offset, call, ret, halt, resume,
    output pc, halted, stk_ovf, stk_unf, stk_cnt
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - LIFO return-address stack; only the pointer is reset
module ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  assign w_wr_idx  = r_cnt[AW-1:0];
  assign w_top_idx = r_cnt[AW-1:0] - 1'b1;
  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign dout      = r_mem[w_top_idx];
  assign count     = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (push && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC mux, RUN/HALTED FSM and sticky stack flags
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int RESET_PC  = DEF_RESET_PC,
  parameter int STK_DEPTH = DEF_STK_DEPTH
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(STK_DEPTH) + 1;

  pc_state_e       r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_ovf, r_unf;
  logic [PC_W-1:0] w_seq, w_tgt, w_off_ext, w_top;
  logic            w_push, w_pop, w_ovf_set, w_unf_set;
  logic            w_full, w_empty;
  logic [CNT_W-1:0] w_cnt;

  // Size cast of a signed operand sign-extends the offset to PC width
  assign w_off_ext = PC_W'($signed(bus.br_offset));
  assign w_seq     = r_pc + 1'b1;
  assign w_tgt     = w_seq + w_off_ext;

  ret_stack #(.W(PC_W), .DEPTH(STK_DEPTH), .CW(CNT_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_seq),
    .dout  (w_top),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.pc_en) begin
          if (bus.halt) begin
            w_state_nxt = S_HALT;
          end else if (bus.ret) begin
            if (!w_empty) begin
              w_pc_nxt = w_top;
              w_pop    = 1'b1;
            end else begin
              w_pc_nxt  = w_seq;
              w_unf_set = 1'b1;
            end
          end else if (bus.call) begin
            w_push    = !w_full;
            w_ovf_set = w_full;
            w_pc_nxt  = w_tgt;
          end else if (bus.Branch) begin
            w_pc_nxt = w_tgt;
          end else begin
            w_pc_nxt = w_seq;
          end
        end
      end
      S_HALT: begin
        if (bus.resume) begin
          w_pc_nxt    = w_seq;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= PC_W'(RESET_PC);
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
      r_unf   <= r_unf | w_unf_set;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.halted  = (r_state == S_HALT);
  assign bus.stk_ovf = r_ovf;
  assign bus.stk_unf = r_unf;
  assign bus.stk_cnt = w_cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int   m_pc;
  bit   m_halt, m_ovf, m_unf;
  int   m_stk[$];

  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit pe, input bit br, input int off,
                      input bit ca, input bit re, input bit ha, input bit rs);
    int seq, tgt;
    rst           = r;
    bus.pc_en     = pe;
    bus.Branch    = br;
    bus.br_offset = off[15:0];
    bus.call      = ca;
    bus.ret       = re;
    bus.halt      = ha;
    bus.resume    = rs;
    @(posedge clk);
    seq = (m_pc + 1) & 32'hFFFF;
    tgt = (seq + off) & 32'hFFFF;
    if (r) begin
      m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
    end else if (!m_halt) begin
      if (pe) begin
        if (ha) m_halt = 1;
        else if (re) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = seq; m_unf = 1; end
        end else if (ca) begin
          if (m_stk.size() < 8) m_stk.push_back(seq);
          else m_ovf = 1;
          m_pc = tgt;
        end else if (br) m_pc = tgt;
        else m_pc = seq;
      end
    end else if (rs) begin
      m_pc = seq; m_halt = 0;
    end
    #1;
    check("pc", 32'(bus.pc), m_pc);
    check("halted", 32'(bus.halted), 32'(m_halt));
    check("stk_ovf", 32'(bus.stk_ovf), 32'(m_ovf));
    check("stk_unf", 32'(bus.stk_unf), 32'(m_unf));
    check("stk_cnt", 32'(bus.stk_cnt), m_stk.size());
  endtask

  task automatic go_to(input int target);
    step(0, 1, 1, target - (m_pc + 1), 0, 0, 0, 0);
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_pc", 32'(bus.pc), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    check("seq_pc3", 32'(bus.pc), 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_pc3", 32'(bus.pc), 3);

    go_to(10);
    step(0, 1, 1, -4, 0, 0, 0, 0);
    check("branch_back", 32'(bus.pc), 7);
    step(0, 0, 1, -4, 0, 0, 0, 0);
    check("branch_no_en", 32'(bus.pc), 7);

    go_to(20);
    step(0, 1, 0, 30, 1, 0, 0, 0);
    check("call_pc", 32'(bus.pc), 51);
    check("call_cnt", 32'(bus.stk_cnt), 1);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("ret_pc", 32'(bus.pc), 21);
    check("ret_cnt", 32'(bus.stk_cnt), 0);

    go_to(100);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 10, 1, 0, 0, 0);
    check("nest_pc", 32'(bus.pc), 133);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("nest_ret1", 32'(bus.pc), 123);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("nest_ret2", 32'(bus.pc), 112);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("nest_ret3", 32'(bus.pc), 101);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1, 0, 0, 0);
    check("ovf_flag", 32'(bus.stk_ovf), 1);
    check("ovf_cnt", 32'(bus.stk_cnt), 8);
    check("ovf_pc", 32'(bus.pc), 9);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("unf_flag", 32'(bus.stk_unf), 1);
    check("unf_pc", 32'(bus.pc), 1);
    go_to(32'hFFFF);
    check("wrap_pre", 32'(bus.pc), 32'hFFFF);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", 32'(bus.pc), 0);

    go_to(40);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    check("halt_pc", 32'(bus.pc), 40);
    check("halt_flag", 32'(bus.halted), 1);
    step(0, 1, 1, 5, 1, 0, 0, 0);
    check("halted_ignore", 32'(bus.pc), 40);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("resume_pc", 32'(bus.pc), 41);
    check("resume_flag", 32'(bus.halted), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("resume_in_run", 32'(bus.pc), 41);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 3, 1, 0, 0, 0);
    check("pre_rst_cnt", 32'(bus.stk_cnt), 2);
    step(1, 1, 0, 3, 1, 0, 0, 0);
    check("rst_mid_pc", 32'(bus.pc), 0);
    check("rst_mid_cnt", 32'(bus.stk_cnt), 0);
    check("rst_mid_unf", 32'(bus.stk_unf), 0);

    step(0, 1, 0, 0, 1, 1, 0, 0);
    check("callret_cnt", 32'(bus.stk_cnt), 0);

    for (int i = 0; i < 400; i++) begin
      int off;
      off = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom)))
                                        : int'($urandom_range(0, 40)) - 20;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, off,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
